// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator engine: key codes, pending
// operator encoding and the display-limit helper.
package calc_pkg;

    localparam logic [4:0] KEY_BKSP = 5'd10;
    localparam logic [4:0] KEY_CLR  = 5'd11;
    localparam logic [4:0] KEY_ADD  = 5'd12;
    localparam logic [4:0] KEY_SUB  = 5'd13;
    localparam logic [4:0] KEY_MUL  = 5'd14;
    localparam logic [4:0] KEY_DIV  = 5'd15;
    localparam logic [4:0] KEY_EQ   = 5'd16;
    localparam logic [4:0] KEY_NEG  = 5'd17;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_t;

    // Largest magnitude representable with the given number of decimal digits.
    function automatic longint calc_lim(input int unsigned digits);
        longint v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction

endpackage

// File: rtl/calc_divider.sv
// W-bit signed restoring divider: one quotient bit per cycle, W iterations,
// operating on magnitudes with the sign applied to the final quotient.
module calc_divider #(
    parameter int W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic                done,
    output logic signed [W-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  q;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic          neg;
    logic [CW-1:0] count;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    // One restoring step: shift in the next dividend bit and try a subtract.
    always_comb begin
        shifted = {rem, q[W-1]};
        trial   = shifted - {1'b0, dvs};
    end

    // Load magnitudes on start, iterate W times, pulse done after the last step.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            q     <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q     <= dividend[W-1] ? -dividend : dividend;
                dvs   <= divisor[W-1]  ? -divisor  : divisor;
                neg   <= dividend[W-1] ^ divisor[W-1];
                rem   <= '0;
                count <= CW'(W);
            end else if (count != '0) begin
                if (!trial[W]) begin
                    rem <= trial[W-1:0];
                    q   <= {q[W-2:0], 1'b1};
                end else begin
                    rem <= shifted[W-1:0];
                    q   <= {q[W-2:0], 1'b0};
                end
                count <= count - 1'b1;
                done  <= (count == CW'(1));
            end
        end
    end

    assign quotient = neg ? -q : q;

endmodule

// File: rtl/calc_core.sv
// Keypad calculator arithmetic engine: signed entry register, accumulator with
// infix pending-operator semantics, range/overflow and divide-by-zero errors.
// Optional feature macro: CALC_DIV_EN enables the sequential divider and the
// DIV operator; without it the DIV key is a no-op and busy is tied low.
module calc_core import calc_pkg::*; #(
    parameter int DIGITS = 6,
    parameter int W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [4:0]          key_code,
    output logic signed [W-1:0] disp_val,
    output logic                disp_neg,
    output logic                err,
    output logic                busy,
    output logic [2:0]          op_pend
);

    typedef logic signed [2*W-1:0] wide_t;

    localparam wide_t                LIM_W      = (2*W)'(calc_lim(DIGITS));
    localparam logic [W-1:0]         APPEND_LIM = W'((calc_lim(DIGITS) + 1) / 10);
    localparam logic signed [W-1:0]  TEN        = W'(10);

    logic signed [W-1:0] entry;
    logic signed [W-1:0] acc;
    op_t                 pend;
    logic                dirty;

    logic                clr;
    logic                digit;
    logic                is_op;
    op_t                 new_op;
    logic [W-1:0]        ent_mag;
    logic [W-1:0]        app_mag;
    logic signed [W-1:0] app_val;
    logic signed [W-1:0] bksp_val;
    wide_t               a_w;
    wide_t               e_w;
    wide_t               r;
    logic                r_ovf;

    // Key decode: classify the incoming code and map operators to op_t.
    always_comb begin
        clr    = key_valid && (key_code == KEY_CLR);
        digit  = (key_code <= 5'd9);
        is_op  = 1'b1;
        new_op = OP_LOAD;
        case (key_code)
            KEY_ADD: new_op = OP_ADD;
            KEY_SUB: new_op = OP_SUB;
            KEY_MUL: new_op = OP_MUL;
`ifdef CALC_DIV_EN
            KEY_DIV: new_op = OP_DIV;
`endif
            KEY_EQ:  new_op = OP_LOAD;
            default: is_op  = 1'b0;
        endcase
    end

    // Entry editing candidates and the pending-operator result with range check.
    always_comb begin
        ent_mag  = entry[W-1] ? -entry : entry;
        app_mag  = ent_mag * W'(10) + W'(key_code);
        app_val  = entry[W-1] ? -app_mag : app_mag;
        bksp_val = entry / TEN;
        a_w      = {{W{acc[W-1]}}, acc};
        e_w      = {{W{entry[W-1]}}, entry};
        case (pend)
            OP_ADD:  r = a_w + e_w;
            OP_SUB:  r = a_w - e_w;
            OP_MUL:  r = a_w * e_w;
            default: r = e_w;
        endcase
        r_ovf = (r > LIM_W) || (r < -LIM_W);
    end

`ifdef CALC_DIV_EN
    logic                div_busy;
    logic                div_start;
    logic                div_done;
    logic signed [W-1:0] div_q;

    assign div_start = key_valid && !err && !div_busy && !clr && is_op && dirty
                       && (pend == OP_DIV) && (entry != '0);
    assign busy = div_busy;

    calc_divider #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (clr),
        .dividend (acc),
        .divisor  (entry),
        .done     (div_done),
        .quotient (div_q)
    );
`else
    assign busy = 1'b0;
`endif

    // Calculator state update: reset/CLR, division completion, then key handling.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            entry    <= '0;
            acc      <= '0;
            pend     <= OP_LOAD;
            dirty    <= 1'b0;
            err      <= 1'b0;
            disp_val <= '0;
`ifdef CALC_DIV_EN
            div_busy <= 1'b0;
        end else if (div_busy) begin
            if (div_done) begin
                div_busy <= 1'b0;
                acc      <= div_q;
                disp_val <= div_q;
            end
`endif
        end else if (key_valid && !err) begin
            if (digit) begin
                if (ent_mag < APPEND_LIM) begin
                    entry    <= app_val;
                    disp_val <= app_val;
                end
                dirty <= 1'b1;
            end else if (key_code == KEY_BKSP) begin
                entry    <= bksp_val;
                disp_val <= bksp_val;
                dirty    <= 1'b1;
            end else if (key_code == KEY_NEG) begin
                entry    <= -entry;
                disp_val <= -entry;
                dirty    <= 1'b1;
            end else if (is_op) begin
                pend <= new_op;
                if (dirty) begin
                    entry <= '0;
                    dirty <= 1'b0;
                    // A pending DIV hands off to the divider; every other op resolves here.
`ifdef CALC_DIV_EN
                    if (pend == OP_DIV) begin
                        if (entry == '0) begin
                            err      <= 1'b1;
                            disp_val <= '0;
                        end else begin
                            div_busy <= 1'b1;
                        end
                    end else
`endif
                    if (r_ovf) begin
                        err      <= 1'b1;
                        disp_val <= '0;
                    end else begin
                        acc      <= r[W-1:0];
                        disp_val <= r[W-1:0];
                    end
                end
            end
        end
    end

    assign disp_neg = disp_val[W-1];
    assign op_pend  = pend;

endmodule

// File: tb/tb_calc_core.sv
// Directed self-checking bench for calc_core with hand-computed expectations.
// Covers the CALC_DIV_EN build and the default build.
module tb_calc_core;

    localparam int W      = 24;
    localparam int DIGITS = 6;

    localparam logic [4:0] K_BKSP = 5'd10;
    localparam logic [4:0] K_CLR  = 5'd11;
    localparam logic [4:0] K_ADD  = 5'd12;
    localparam logic [4:0] K_SUB  = 5'd13;
    localparam logic [4:0] K_MUL  = 5'd14;
    localparam logic [4:0] K_DIV  = 5'd15;
    localparam logic [4:0] K_EQ   = 5'd16;
    localparam logic [4:0] K_NEG  = 5'd17;

    logic                clk;
    logic                rst;
    logic                key_valid;
    logic [4:0]          key_code;
    logic signed [W-1:0] disp_val;
    logic                disp_neg;
    logic                err;
    logic                busy;
    logic [2:0]          op_pend;

    int checks;
    int failures;

    calc_core #(.DIGITS(DIGITS), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .disp_val  (disp_val),
        .disp_neg  (disp_neg),
        .err       (err),
        .busy      (busy),
        .op_pend   (op_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; outputs afterwards are the cycle-1 values.
    task automatic press(input logic [4:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'd31;
    endtask

    task automatic num(input int v);
        int digs[$];
        if (v == 0) digs.push_front(0);
        while (v > 0) begin
            digs.push_front(v % 10);
            v = v / 10;
        end
        foreach (digs[i]) press(5'(digs[i]));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        key_valid = 1'b1;
        key_code  = 5'd5;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 5'd31;

        check("rst_disp", disp_val, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_op", op_pend, 0);
        check("rst_neg", disp_neg, 0);

        num(123);
        check("d123_disp", disp_val, 123);
        check("d123_dirty", dut.dirty, 1);
        check("d123_op", op_pend, 0);

        press(K_CLR);
        num(9999999);
        check("d7_disp", disp_val, 999999);
        press(K_BKSP);
        check("bksp_disp", disp_val, 99999);
        press(K_NEG);
        check("neg_disp", disp_val, -99999);
        check("neg_flag", disp_neg, 1);
        press(K_BKSP);
        check("bksp_neg", disp_val, -9999);

        press(K_CLR);
        num(12);
        press(K_ADD);
        check("add_disp", disp_val, 12);
        check("add_op", op_pend, 1);
        num(30);
        press(K_SUB);
        check("sub_disp", disp_val, 42);
        check("sub_op", op_pend, 2);
        num(5);
        press(K_EQ);
        check("eq_disp", disp_val, 37);
        check("eq_op", op_pend, 0);

        press(K_CLR);
        num(7);
        press(K_NEG);
        press(K_MUL);
        check("mul_op", op_pend, 3);
        check("mul_acc", disp_val, -7);
        num(6);
        press(K_EQ);
        check("mul_disp", disp_val, -42);
        check("mul_neg", disp_neg, 1);
        press(K_ADD);
        press(K_SUB);
        check("repl_op", op_pend, 2);
        check("repl_disp", disp_val, -42);
        num(2);
        press(K_EQ);
        check("cont_disp", disp_val, -44);

        press(K_CLR);
        num(1000);
        press(K_MUL);
        num(1000);
        press(K_EQ);
        check("ovf_err", err, 1);
        check("ovf_disp", disp_val, 0);
        num(5);
        check("ovf_ign", disp_val, 0);
        check("ovf_err_held", err, 1);
        press(K_CLR);
        check("clr_err", err, 0);
        check("clr_disp", disp_val, 0);

        num(999999);
        press(K_ADD);
        num(1);
        press(K_EQ);
        check("add_ovf", err, 1);
        press(K_CLR);

        num(4);
        press(5'd20);
        check("nop_disp", disp_val, 4);
        check("nop_op", op_pend, 0);
        press(K_CLR);

`ifdef CALC_DIV_EN
        begin
            int bcnt;
            num(7);
            press(K_NEG);
            press(K_DIV);
            check("div_op", op_pend, 4);
            check("div_ld", disp_val, -7);
            num(2);
            press(K_EQ);
            check("div_op_eq", op_pend, 0);
            bcnt = 0;
            for (int i = 0; i < 100 && busy; i++) begin
                bcnt++;
                if (i == 5) begin
                    key_valid = 1'b1;
                    key_code  = 5'd9;
                end
                @(negedge clk);
                key_valid = 1'b0;
                key_code  = 5'd31;
            end
            check("div_busy_len", bcnt, W + 1);
            check("div_q", disp_val, -3);
            check("div_q_neg", disp_neg, 1);
            check("div_err", err, 0);
            press(K_EQ);
            check("div_drop", disp_val, -3);

            press(K_CLR);
            num(100);
            press(K_DIV);
            num(7);
            press(K_EQ);
            wait_idle("div2_idle");
            check("div2_q", disp_val, 14);

            press(K_CLR);
            num(8);
            press(K_DIV);
            num(0);
            press(K_EQ);
            check("dz_err", err, 1);
            check("dz_disp", disp_val, 0);
            check("dz_busy", busy, 0);

            press(K_CLR);
            num(9);
            press(K_DIV);
            num(3);
            press(K_EQ);
            check("abort_busy_pre", busy, 1);
            repeat (3) @(negedge clk);
            press(K_CLR);
            check("abort_busy", busy, 0);
            check("abort_disp", disp_val, 0);
            check("abort_op", op_pend, 0);
            repeat (W + 4) @(negedge clk);
            check("abort_late", disp_val, 0);
            check("abort_late_busy", busy, 0);
        end
`else
        num(8);
        press(K_DIV);
        check("nodiv_op", op_pend, 0);
        check("nodiv_busy", busy, 0);
        check("nodiv_disp", disp_val, 8);
        num(2);
        check("nodiv_entry", disp_val, 82);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
